// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch/decode stage register and a
// direct-mapped instruction cache (4-word lines) refilled over a req/gnt + beat port.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_en,
  input  logic [31:0] branch_PC,
  input  logic        load_stall,
  input  logic        branch_stall,
  input  logic        dcache_stall,
  input  logic        mul_stall,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        icache_stall,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic        mem_req,
  output logic [31:0] mem_addr
);

  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 32 - IDX_BITS - 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [31:0]          pc_q, pc_d;
  logic [31:0]          fdPc_q, fdPc_d;
  logic [31:0]          fdInstr_q, fdInstr_d;
  logic [1:0]           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [31:0]          data_q [LINES][4];

  logic [1:0]           word;
  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 hit;
  logic                 beatWe;
  logic                 lastBeat;

  assign word     = pc_q[3:2];
  assign idx      = pc_q[IDX_BITS+3:4];
  assign tag      = pc_q[31:IDX_BITS+4];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign beatWe   = (state_q == FILL) && mem_rvalid;
  assign lastBeat = beatWe && (cnt_q == 2'd3);

  assign icache_stall = (state_q != IDLE) || !hit;
  assign mem_req      = (state_q == REQ);
  assign mem_addr     = {pc_q[31:4], 4'b0000};
  assign fd_pc        = fdPc_q;
  assign fd_instr     = fdInstr_q;

  // Refill FSM runs independently of pipeline stalls and redirects; a started
  // refill always completes, even for a line fetched down a wrong path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (!hit) state_d = REQ;
      REQ: begin
        if (mem_gnt) begin
          state_d = FILL;
          cnt_d   = 2'd0;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    fdPc_d    = fdPc_q;
    fdInstr_d = fdInstr_q;
    if (dcache_stall || mul_stall || icache_stall) begin
      pc_d = pc_q;
    end else if (branch_en) begin
      pc_d      = branch_PC;
      fdPc_d    = 32'h0;
      fdInstr_d = 32'h0;
    end else if (!(load_stall || branch_stall)) begin
      fdPc_d    = pc_q;
      fdInstr_d = data_q[idx][word];
      pc_d      = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      fdPc_q    <= 32'h0;
      fdInstr_q <= 32'h0;
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      valid_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      fdPc_q    <= fdPc_d;
      fdInstr_q <= fdInstr_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (lastBeat) valid_q[idx] <= 1'b1;
    end
  end

  // Cache arrays carry no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clock) begin
    if (!reset && beatWe) data_q[idx][cnt_q] <= mem_rdata;
    if (!reset && lastBeat) tag_q[idx] <= tag;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32 pipeline; produces fd_pc/fd_instr consumed by decode.
- Honours decode's redirect (branch_en/branch_PC) and hazard stalls (load_stall, branch_stall), and the global dcache_stall/mul_stall.
- Holds a direct-mapped instruction cache (4-word lines) with a miss/refill FSM on a request/grant + beat memory port; drives icache_stall to freeze the pipeline during refills.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset
IDX_BITS, 3, log2 of cache line count (default 8 lines x 4 words = 128 B)

Ports:
clock  in  1  single clock; all state updates on posedge clock
reset  in  1  synchronous, active-high
branch_en  in  1  taken-branch redirect from decode
branch_PC  in  32  redirect target
load_stall  in  1  decode load-use hazard; hold fetch
branch_stall  in  1  decode branch-operand hazard; hold fetch
dcache_stall  in  1  global freeze
mul_stall  in  1  global freeze
mem_gnt  in  1  memory accepted the line request
mem_rvalid  in  1  refill beat valid
mem_rdata  in  32  refill beat data, word 0..3 in order
icache_stall  out  1  miss pending or refill in progress
fd_pc  out  32  registered PC of fd_instr
fd_instr  out  32  registered instruction; 0 = bubble
mem_req  out  1  line request, held until mem_gnt
mem_addr  out  32  line base address (pc & ~32'hF)

Behaviour:
- Reset (synchronous, active-high): pc<=RESET_PC; fd_pc<=0; fd_instr<=0; all valid bits<=0; FSM<=IDLE; beat counter<=0; mem_req<=0.
- Address split: word=pc[3:2]; idx=pc[IDX_BITS+3:4]; tag=pc[31:IDX_BITS+4]. pc[1:0] are ignored.
- hit = valid[idx] && tag_ram[idx]==tag. Lookup is combinational; data is read from the data array.
- icache_stall = (state!=IDLE) || !hit. Combinational.
- FSM:
  - IDLE: on !hit, go to REQ.
  - REQ: mem_req=1, mem_addr={pc[31:4],4'b0}. On mem_gnt, go to FILL with counter=0.
  - FILL: each mem_rvalid writes mem_rdata to data[idx][counter] and increments counter. On the beat where counter==3, write tag, set valid[idx]=1, go to IDLE. The next cycle hits.
  - The FSM advances regardless of dcache_stall, mul_stall, load_stall, branch_stall and branch_en. An in-flight refill is never aborted; the wrong-path line is still installed.
- Stage register / PC update, in priority order:
  1. reset.
  2. dcache_stall || mul_stall || icache_stall: hold pc, fd_pc, fd_instr.
  3. branch_en: pc<=branch_PC; fd_pc<=0; fd_instr<=0 (flush wrong-path slot).
  4. load_stall || branch_stall: hold pc, fd_pc, fd_instr.
  5. else: fd_pc<=pc; fd_instr<=data[idx][word]; pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- A redirect asserted during icache_stall is ignored that cycle. Decode keeps branch_en asserted from the held fd_instr until the stall clears, so the redirect is then taken.
- A hit latency of 1 cycle (pc to fd_instr). Miss penalty = cycles to mem_gnt + 4 beats + 1 lookup cycle.
- Reset mid-refill: FSM returns to IDLE and mem_req drops the same edge. The memory side drops outstanding beats on reset. Beats arriving in IDLE/REQ are ignored.
- mem_rvalid is only sampled in FILL. Beats after the fourth are ignored.

Test Plan:
- Cold start: reset, RESET_PC=0, memory words 0x00000013,0x00100093,0x00200113,0x00300193 at 0x0..0xC.
  - Required: mem_req with mem_addr=0; icache_stall=1 until fill completes.
  - Then fd_instr=0x00000013/fd_pc=0, 0x00100093/4, 0x00200113/8, 0x00300193/0xC on consecutive cycles, no further mem_req within the line.
- Line crossing: pc reaches 0x10 -> new miss, mem_addr=0x10. Re-fetch of 0x0 after a branch back hits with no mem_req.
- Branch redirect: fd holds 0x8, branch_en=1 with branch_PC=0x4 for one cycle -> next cycle fd_instr=0, fd_pc=0. The following cycle fd_pc=4, fd_instr=0x00100093.
- Hazard hold: load_stall=1 for 2 cycles with fd_pc=0x8 -> fd_pc/fd_instr/pc unchanged for both cycles, then advance to 0xC. The same holds with dcache_stall=1 and mul_stall=1.
- Conflict eviction (IDX_BITS=3): fetch 0x0 then 0x80 (same idx, different tag) -> refill at 0x80. A later fetch of 0x0 misses again with mem_addr=0.
- Reset mid-fill: assert reset after 2 beats -> mem_req=0, icache_stall=1 next cycle (all invalid), pc=RESET_PC. A fresh request is issued for 0x0 and the line is fully refilled with correct data.
